snn_seq: RTL and testbench
==========================

Name: snn_seq

Overview:
Top-level sequencer for the digit-recognition datapath. Receives a packed 784-pixel binary image as 98 UART bytes and unpacks it bit-by-bit into the input-unit RAM. It then starts the SNN core and owns the input-RAM address mux while the core runs. When the core finishes, it transmits the result as one ASCII character over UART TX.

Parameters:
NUM_BITS, 784, image size in pixels; must be a multiple of 8
ASCII_ZERO, 8'h30, offset added to the digit for TX

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
rx_rdy  in  1  UART RX byte available (level, held until cleared)
rx_data  in  8  UART RX byte
rx_clr_rdy  out  1  one-cycle pulse acknowledging rx_data
ram_addr  out  10  input-unit RAM address (muxed loader/core)
ram_we  out  1  input-unit RAM write enable
ram_d  out  1  input-unit RAM write data (pixel bit)
core_addr  in  10  core's input-unit address
core_start  out  1  one-cycle start pulse to core
core_done  in  1  core done pulse
core_digit  in  4  core result, valid when core_done
tx_start  out  1  one-cycle pulse to UART TX
tx_data  out  8  TX byte
tx_done  in  1  TX complete pulse
digit  out  4  last registered result
busy  out  1  high in every state except LOAD_WAIT with bit_cnt==0

Behaviour:
- Reset: all outputs 0; state LOAD_WAIT; bit_cnt=0; shift=0; digit=0.
- Reset is synchronous. Reset mid-operation discards any partial image and any pending TX; the RAM contents are not cleared.
- States and transitions:
  - LOAD_WAIT: when rx_rdy=1, latch rx_data into shift, pulse rx_clr_rdy for the same cycle, set bit_idx=0, go to LOAD_SHIFT.
  - LOAD_SHIFT: ram_we=1, ram_d=shift[0], ram_addr=bit_cnt. Each cycle shift>>=1, bit_cnt++, bit_idx++. After 8 writes: if bit_cnt==NUM_BITS go to START, else go to LOAD_WAIT. Bits are written LSB first, so byte k bit j lands at address 8k+j.
  - START: core_start=1 for exactly one cycle; bit_cnt cleared; go to WAIT_CORE.
  - WAIT_CORE: ram_addr=core_addr, ram_we=0. When core_done=1, register digit<=core_digit and go to TX.
  - TX: tx_start=1 for one cycle, tx_data=ASCII_ZERO+digit; go to TX_WAIT.
  - TX_WAIT: hold tx_data. When tx_done=1, go to LOAD_WAIT.
- Address mux: ram_addr=core_addr only in WAIT_CORE. Otherwise it is the loader address: bit_cnt during LOAD_SHIFT, 0 elsewhere. ram_we is never 1 outside LOAD_SHIFT.
- Per-byte latency: rx_rdy sampled at cycle t; writes occur at t+1..t+8; next byte accepted no earlier than t+9.
- rx_rdy outside LOAD_WAIT is not acknowledged. The byte stays pending and is consumed by the next image load.
- core_done is ignored outside WAIT_CORE. tx_done is ignored outside TX_WAIT.
- bit_cnt is 10 bits and saturates logic-wise at NUM_BITS; it never wraps past 783 into a write.
- ASCII add is 8-bit unsigned with {4'h0,digit}. Digits 0–9 map to 8'h30–8'h39; 10–15 map to 8'h3A–8'h3F, undefined at system level but passed through.

Decomposition:
- Package snn_pkg holds:
  - enum seq_state_t {LOAD_WAIT, LOAD_SHIFT, START, WAIT_CORE, TX, TX_WAIT}
  - localparams NUM_INPUT_BITS=784 and ASCII_ZERO=8'h30
- Sub-module snn_byte_unpack holds the 8-bit shift register, 3-bit bit_idx and the last-bit flag. Interface: load, shift_en, byte_in, bit_out, last.
- The FSM, counters and address mux stay in snn_seq.

Test Plan:
- Reset then 98 bytes of 8'hA5 → RAM holds pattern 1,0,1,0,0,1,0,1 repeated at addresses 0–783. core_start pulses once, exactly 1 cycle after the 8th write of byte 97.
- Byte 8'h01 first → address 0 written 1, addresses 1–7 written 0. rx_clr_rdy is high for exactly one cycle per byte, 98 pulses total.
- In WAIT_CORE, drive core_addr=10'h2A5 → ram_addr=10'h2A5 and ram_we=0. Assert core_done with core_digit=7 → tx_start pulses one cycle later with tx_data=8'h37, digit=7.
- rx_rdy held high during WAIT_CORE/TX_WAIT → no rx_clr_rdy. After tx_done the FSM returns to LOAD_WAIT and acknowledges the pending byte on the next cycle.
- Assert rst_n=0 for one cycle after 50 bytes → state LOAD_WAIT, bit_cnt=0. A following full 98-byte image starts writing at address 0, and core_start fires only after 98 more bytes.
- core_done and tx_done pulsed during load → ignored; no state change and no TX.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared types and constants for the digit-recognition sequencer.
// Holds the sequencer state encoding, image size and ASCII offset.
package snn_pkg;

   typedef enum logic [2:0] {
      LOAD_WAIT,
      LOAD_SHIFT,
      START,
      WAIT_CORE,
      TX,
      TX_WAIT
   } seq_state_t;

   localparam int         NUM_INPUT_BITS = 784;
   localparam logic [7:0] ASCII_ZERO     = 8'h30;

endpackage

// File: rtl/snn_byte_unpack.sv
// Byte-to-bit unpacker: serialises one received byte LSB first.
// Ports: clk, rst_n (sync, active low), load/byte_in capture a new byte,
// shift_en advances one bit, bit_out is the current bit, last marks bit 7.
module snn_byte_unpack (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic       shift_en,
   input  logic [7:0] byte_in,
   output logic       bit_out,
   output logic       last
);

   logic [7:0] shift;
   logic [2:0] bit_idx;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shift   <= '0;
         bit_idx <= '0;
      end else if (load) begin
         shift   <= byte_in;
         bit_idx <= '0;
      end else if (shift_en) begin
         shift   <= {1'b0, shift[7:1]};
         bit_idx <= bit_idx + 3'd1;
      end
   end

   assign bit_out = shift[0];
   assign last    = (bit_idx == 3'd7);

endmodule

// File: rtl/snn_seq.sv
// Sequencer: loads a packed binary image from UART RX into the input RAM,
// runs the SNN core, then sends the resulting digit as ASCII on UART TX.
// Ports: rx_rdy/rx_data/rx_clr_rdy (RX byte handshake), ram_addr/ram_we/ram_d
// (input RAM, muxed with core_addr while the core runs), core_start/core_done/
// core_digit (core control), tx_start/tx_data/tx_done (TX), digit, busy.
module snn_seq #(
   parameter int         NUM_BITS   = snn_pkg::NUM_INPUT_BITS,
   parameter logic [7:0] ASCII_ZERO = snn_pkg::ASCII_ZERO
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_rdy,
   input  logic [7:0] rx_data,
   output logic       rx_clr_rdy,
   output logic [9:0] ram_addr,
   output logic       ram_we,
   output logic       ram_d,
   input  logic [9:0] core_addr,
   output logic       core_start,
   input  logic       core_done,
   input  logic [3:0] core_digit,
   output logic       tx_start,
   output logic [7:0] tx_data,
   input  logic       tx_done,
   output logic [3:0] digit,
   output logic       busy
);

   import snn_pkg::*;

   localparam logic [9:0] LAST_BIT = 10'(NUM_BITS);

   seq_state_t state;
   logic [9:0] bit_cnt;
   logic [9:0] nxt_cnt;
   logic       bit_out;
   logic       last;
   logic       shifting;

   assign shifting = (state == LOAD_SHIFT);

   // Byte is acknowledged in the cycle it is accepted.
   assign rx_clr_rdy = rst_n & rx_rdy & (state == LOAD_WAIT);

   // Count saturates so a stray shift can never address past the image.
   assign nxt_cnt = (bit_cnt == LAST_BIT) ? bit_cnt : bit_cnt + 10'd1;

   snn_byte_unpack u_unpack (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (rx_clr_rdy),
      .shift_en (shifting),
      .byte_in  (rx_data),
      .bit_out  (bit_out),
      .last     (last)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= LOAD_WAIT;
         bit_cnt <= '0;
         digit   <= '0;
         tx_data <= '0;
      end else begin
         unique case (state)
            LOAD_WAIT: begin
               if (rx_rdy) state <= LOAD_SHIFT;
            end
            LOAD_SHIFT: begin
               bit_cnt <= nxt_cnt;
               if (last)
                  state <= (nxt_cnt == LAST_BIT) ? START : LOAD_WAIT;
            end
            START: begin
               bit_cnt <= '0;
               state   <= WAIT_CORE;
            end
            WAIT_CORE: begin
               if (core_done) begin
                  digit   <= core_digit;
                  tx_data <= ASCII_ZERO + {4'h0, core_digit};
                  state   <= TX;
               end
            end
            TX: begin
               state <= TX_WAIT;
            end
            TX_WAIT: begin
               if (tx_done) state <= LOAD_WAIT;
            end
            default: state <= LOAD_WAIT;
         endcase
      end
   end

   always_comb begin
      ram_addr = '0;
      unique case (1'b1)
         (state == WAIT_CORE): ram_addr = core_addr;
         shifting:             ram_addr = bit_cnt;
         default: ;
      endcase
   end

   assign ram_we     = shifting & (bit_cnt != LAST_BIT);
   assign ram_d      = shifting & bit_out;
   assign core_start = (state == START);
   assign tx_start   = (state == TX);
   assign busy       = !((state == LOAD_WAIT) && (bit_cnt == '0));

endmodule

// File: tb/tb_snn_seq.sv
// Self-checking bench for snn_seq: image loads, core handoff, TX and reset.
// Expected RAM image is derived from the sent bytes (byte k bit j -> 8k+j).
module tb_snn_seq;

   logic       clk = 0;
   logic       rst_n;
   logic       rx_rdy;
   logic [7:0] rx_data;
   logic       rx_clr_rdy;
   logic [9:0] ram_addr;
   logic       ram_we;
   logic       ram_d;
   logic [9:0] core_addr;
   logic       core_start;
   logic       core_done;
   logic [3:0] core_digit;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx_done;
   logic [3:0] digit;
   logic       busy;

   snn_seq dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_rdy     (rx_rdy),
      .rx_data    (rx_data),
      .rx_clr_rdy (rx_clr_rdy),
      .ram_addr   (ram_addr),
      .ram_we     (ram_we),
      .ram_d      (ram_d),
      .core_addr  (core_addr),
      .core_start (core_start),
      .core_done  (core_done),
      .core_digit (core_digit),
      .tx_start   (tx_start),
      .tx_data    (tx_data),
      .tx_done    (tx_done),
      .digit      (digit),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Monitor: models the input RAM and logs handshake events.
   logic ram_m [1024];
   int   cyc = 0;
   int   n_clr = 0, n_we = 0, n_cs = 0, n_tx = 0;
   int   last_we_cyc = 0, cs_cyc = 0;
   int   clr_q[$];
   int   we_addr_q[$];

   always @(posedge clk) begin
      if (rx_clr_rdy) begin
         n_clr++;
         clr_q.push_back(cyc);
      end
      if (ram_we) begin
         ram_m[ram_addr] = ram_d;
         we_addr_q.push_back(int'(ram_addr));
         n_we++;
         last_we_cyc = cyc;
      end
      if (core_start) begin
         n_cs++;
         cs_cyc = cyc;
      end
      if (tx_start) n_tx++;
      cyc++;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [7:0] first;
      logic [3:0] dig;
      logic [7:0] exp_tx;
   } vec_t;

   vec_t       tbl [6];
   logic [7:0] img [98];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      rx_data = b;
      rx_rdy  = 1;
      #1;
      while (!rx_clr_rdy && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("rx_accept", {31'b0, rx_clr_rdy}, 1);
      @(negedge clk);
      rx_rdy = 0;
   endtask

   task automatic load_image(input int from, input bit inject);
      int tx0;
      for (int k = from; k < 98; k++) begin
         send_byte(img[k]);
         if (inject && k == 40) begin
            tx0 = n_tx;
            core_done  = 1;
            core_digit = 4'd9;
            tx_done    = 1;
            @(negedge clk);
            core_done = 0;
            tx_done   = 0;
            @(negedge clk);
            chk("ignore_done_tx", n_tx, tx0);
            chk("ignore_done_busy", {31'b0, busy}, 1);
         end
      end
   endtask

   task automatic wait_cs(input int base);
      int n = 0;
      while (n_cs == base && n < 1200) begin
         @(negedge clk);
         n++;
      end
      chk("core_start_once", n_cs, base + 1);
   endtask

   task automatic check_image(input int bclr, input int bwe);
      int bad = 0;
      for (int a = 0; a < 784; a++)
         if (ram_m[a] !== img[a / 8][a % 8]) bad++;
      chk("img_bits_bad", bad, 0);
      chk("rx_clr_count", n_clr - bclr, 98);
      chk("write_count", n_we - bwe, 784);
      chk("first_addr", we_addr_q[bwe], 0);
      chk("last_addr", we_addr_q[bwe + 783], 783);
      chk("start_latency", cs_cyc - last_we_cyc, 1);
   endtask

   task automatic finish_core(input logic [3:0] dig, input logic [7:0] exp);
      logic [9:0] ca;
      int         tx0;
      tx0 = n_tx;
      ca  = 10'($urandom_range(0, 1023));
      core_addr = ca;
      #1;
      chk("mux_addr", {22'b0, ram_addr}, {22'b0, ca});
      chk("mux_we", {31'b0, ram_we}, 0);
      chk("wait_busy", {31'b0, busy}, 1);
      @(negedge clk);
      core_digit = dig;
      core_done  = 1;
      @(negedge clk);
      core_done = 0;
      chk("tx_start", {31'b0, tx_start}, 1);
      chk("tx_data", {24'b0, tx_data}, {24'b0, exp});
      chk("digit", {28'b0, digit}, {28'b0, dig});
      @(negedge clk);
      chk("tx_start_pulse", {31'b0, tx_start}, 0);
      chk("tx_data_hold", {24'b0, tx_data}, {24'b0, exp});
      repeat (3) @(negedge clk);
      chk("tx_count", n_tx - tx0, 1);
      tx_done = 1;
      @(negedge clk);
      tx_done = 0;
      chk("idle_busy", {31'b0, busy}, 0);
   endtask

   initial begin
      int bclr, bwe, bcs, bad;
      tbl[0] = '{8'h01, 4'd7,  8'h37};
      tbl[1] = '{8'hFF, 4'd0,  8'h30};
      tbl[2] = '{8'h00, 4'd9,  8'h39};
      tbl[3] = '{8'h80, 4'd10, 8'h3A};
      tbl[4] = '{8'h5A, 4'd15, 8'h3F};
      tbl[5] = '{8'h3C, 4'd3,  8'h33};

      rst_n = 0; rx_rdy = 0; rx_data = 0; core_addr = 0;
      core_done = 0; core_digit = 0; tx_done = 0;
      repeat (3) @(negedge clk);
      chk("rst_clr", {31'b0, rx_clr_rdy}, 0);
      chk("rst_addr", {22'b0, ram_addr}, 0);
      chk("rst_we", {31'b0, ram_we}, 0);
      chk("rst_d", {31'b0, ram_d}, 0);
      chk("rst_cstart", {31'b0, core_start}, 0);
      chk("rst_txstart", {31'b0, tx_start}, 0);
      chk("rst_txdata", {24'b0, tx_data}, 0);
      chk("rst_digit", {28'b0, digit}, 0);
      chk("rst_busy", {31'b0, busy}, 0);
      rst_n = 1;
      @(negedge clk);

      // All-A5 image with rx_rdy held high throughout.
      for (int k = 0; k < 98; k++) img[k] = 8'hA5;
      bclr = n_clr; bwe = n_we; bcs = n_cs;
      rx_data = 8'hA5;
      rx_rdy  = 1;
      wait_cs(bcs);
      check_image(bclr, bwe);
      bad = 0;
      for (int i = bclr + 1; i < bclr + 98; i++)
         if (clr_q[i] - clr_q[i - 1] != 9) bad++;
      chk("byte_gap", bad, 0);
      bclr = n_clr;
      finish_core(4'd7, 8'h37);
      chk("no_ack_busy", n_clr, bclr);
      chk("pending_ack", {31'b0, rx_clr_rdy}, 1);
      bwe = n_we; bcs = n_cs;
      @(negedge clk);
      rx_rdy = 0;

      // Pending A5 becomes byte 0 of the next image.
      for (int k = 1; k < 98; k++) img[k] = 8'($urandom);
      load_image(1, 0);
      wait_cs(bcs);
      check_image(bclr, bwe);
      finish_core(4'd5, 8'h35);

      for (int t = 0; t < 6; t++) begin
         img[0] = tbl[t].first;
         for (int k = 1; k < 98; k++) img[k] = 8'($urandom);
         bclr = n_clr; bwe = n_we; bcs = n_cs;
         load_image(0, t == 2);
         wait_cs(bcs);
         check_image(bclr, bwe);
         chk("byte0_bits", {24'b0, ram_m[7], ram_m[6], ram_m[5], ram_m[4],
             ram_m[3], ram_m[2], ram_m[1], ram_m[0]}, {24'b0, tbl[t].first});
         finish_core(tbl[t].dig, tbl[t].exp_tx);
      end

      // Reset after 50 bytes discards the partial image.
      for (int k = 0; k < 98; k++) img[k] = 8'($urandom);
      bcs = n_cs;
      for (int k = 0; k < 50; k++) send_byte(img[k]);
      rst_n = 0;
      @(negedge clk);
      rst_n = 1;
      chk("mid_rst_busy", {31'b0, busy}, 0);
      chk("mid_rst_digit", {28'b0, digit}, 0);
      chk("mid_rst_we", {31'b0, ram_we}, 0);
      for (int k = 0; k < 98; k++) img[k] = 8'($urandom);
      bclr = n_clr; bwe = n_we;
      for (int k = 0; k < 97; k++) send_byte(img[k]);
      repeat (20) @(negedge clk);
      chk("no_early_start", n_cs, bcs);
      send_byte(img[97]);
      wait_cs(bcs);
      check_image(bclr, bwe);
      finish_core(4'd2, 8'h32);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
